// File: rtl/seg_scan_if.sv
// Display-value load channel for seg_scan_ctrl.
//   ld_valid : source offers a new 16-bit display value
//   ld_ready : controller can take a value (no value is buffered)
//   ld_data  : display value, nibble k ([4k+3:4k]) is digit k
// The master drives the value; the scan controller is the slave.
interface seg_scan_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;

    modport master (output ld_valid, output ld_data, input ld_ready);
    modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. It drives one digit at a time and puts a
// blanking gap after each digit to suppress ghosting. A new display value
// is accepted over a valid/ready channel. It is applied only at a frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ld          load channel (seg_scan_if.slave): ld_valid, ld_ready, ld_data
//   en_mask     per-digit enable; a 0 keeps that digit dark, timing unchanged
//   an          anode enables, active-low, at most one bit low
//   nibble      nibble of the current digit, to the external decoder
//   frame_start one-cycle pulse when the digit-0 slot begins
//
// FSM states:
//   state    | meaning
//   ST_BLANK | all anodes off for BLANK_TICKS ticks, nibble held
//   ST_SHOW  | current digit driven for ON_TICKS ticks
module seg_scan_ctrl #(
    parameter int DIV         = 100000,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    seg_scan_if.slave    ld,
    input  logic [3:0]   en_mask,
    output logic [3:0]   an,
    output logic [3:0]   nibble,
    output logic         frame_start
);

    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [PW-1:0] pre_cnt;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_nxt;
    state_t        state;
    state_t        state_nxt;
    logic [1:0]    digit;
    logic [1:0]    digit_nxt;
    logic [15:0]   active;
    logic [15:0]   active_nxt;
    logic [15:0]   pend_data;
    logic          pending;
    logic          pending_nxt;
    logic          tick;
    logic          boundary;
    logic          apply;
    logic          xfer;

    assign tick = (pre_cnt == PRE_LAST);

    always_comb begin
        state_nxt    = state;
        digit_nxt    = digit;
        tick_cnt_nxt = tick_cnt;
        if (tick) begin
            if (state == ST_SHOW) begin
                if (tick_cnt == ON_LAST) begin
                    state_nxt    = ST_BLANK;
                    tick_cnt_nxt = '0;
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end else begin
                if (tick_cnt == BLANK_LAST) begin
                    state_nxt    = ST_SHOW;
                    digit_nxt    = digit + 2'd1;
                    tick_cnt_nxt = '0;
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end
        end
    end

    // Frame boundary: the last blank tick after digit 3, i.e. the edge
    // that starts the digit-0 slot.
    assign boundary = tick && (state == ST_BLANK) && (tick_cnt == BLANK_LAST)
                      && (digit == 2'd3);
    assign apply    = boundary && pending;
    assign xfer     = ld.ld_valid && ld.ld_ready;

    assign active_nxt = apply ? pend_data : active;

    // Clearing on apply wins over a transfer. A transfer cannot happen
    // while pending is set, because ready is low. So data accepted on the
    // boundary cycle is held for the next frame, not this one.
    assign pending_nxt = apply ? 1'b0 : (xfer ? 1'b1 : pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            tick_cnt    <= '0;
            state       <= ST_BLANK;
            digit       <= 2'd3;
            active      <= '0;
            pend_data   <= '0;
            pending     <= 1'b0;
            an          <= 4'hF;
            nibble      <= 4'h0;
            frame_start <= 1'b0;
            ld.ld_ready <= 1'b1;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
            tick_cnt    <= tick_cnt_nxt;
            state       <= state_nxt;
            digit       <= digit_nxt;
            active      <= active_nxt;
            pending     <= pending_nxt;
            frame_start <= boundary;
            ld.ld_ready <= ~pending_nxt;
            if (xfer) begin
                pend_data <= ld.ld_data;
            end
            // Outputs follow the next state so they change on the same edge
            // as the FSM. en_mask is applied every cycle, even mid-slot.
            if (state_nxt == ST_SHOW && en_mask[digit_nxt]) begin
                an <= ~(4'b0001 << digit_nxt);
            end else begin
                an <= 4'hF;
            end
            if (state_nxt == ST_SHOW) begin
                nibble <= active_nxt[{digit_nxt, 2'b00} +: 4];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    localparam int DIV   = 4;
    localparam int ON    = 2;
    localparam int BL    = 1;
    localparam int SLOT  = (ON + BL) * DIV;
    localparam int INIT  = BL * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] en_mask = 4'hF;
    logic [3:0] an;
    logic [3:0] nibble;
    logic       frame_start;

    seg_scan_if sif ();

    seg_scan_ctrl #(.DIV(DIV), .ON_TICKS(ON), .BLANK_TICKS(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld          (sif),
        .en_mask     (en_mask),
        .an          (an),
        .nibble      (nibble),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the scan position comes from elapsed cycles since
    // reset release. The handshake and the frame-boundary apply rule are
    // held as plain variables.
    int          t;
    logic [15:0] m_act, m_pdata;
    bit          m_pend, m_ready, m_fs, m_show;
    int          m_dig;
    logic [3:0]  m_an, m_nib;

    typedef struct {
        int         n;
        logic [3:0] en;
        logic [3:0] an_e;
        logic       fs_e;
    } vec_t;
    vec_t tbl[$];

    function automatic void scan_pos(input int tt, output bit show, output int dig, output bit fs);
        int p;
        int off;
        p = tt - INIT;
        if (p < 0) begin
            show = 0; dig = 3; fs = 0;
        end else begin
            off  = p % SLOT;
            dig  = (p / SLOT) % 4;
            show = (off < ON * DIV);
            fs   = (off == 0) && (dig == 0);
        end
    endfunction

    task automatic model_reset();
        t = 0; m_act = '0; m_pdata = '0; m_pend = 0; m_ready = 1;
        m_an = 4'hF; m_nib = 4'h0; m_fs = 0; m_show = 0; m_dig = 3;
    endtask

    task automatic model_edge();
        bit xfer;
        xfer = sif.ld_valid && m_ready;
        t++;
        scan_pos(t, m_show, m_dig, m_fs);
        if (m_fs && m_pend) begin
            m_act  = m_pdata;
            m_pend = 0;
        end else if (xfer) begin
            m_pend  = 1;
            m_pdata = sif.ld_data;
        end
        m_ready = !m_pend;
        if (m_show) begin
            m_an  = en_mask[m_dig] ? 4'(~(4'b0001 << m_dig)) : 4'hF;
            m_nib = m_act[m_dig*4 +: 4];
        end else begin
            m_an = 4'hF;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("an", 16'(an), 16'(m_an));
        chk("nibble", 16'(nibble), 16'(m_nib));
        chk("frame_start", 16'(frame_start), 16'(m_fs));
        chk("ld_ready", 16'(sif.ld_ready), 16'(m_ready));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk_model();
        end
    endtask

    initial begin
        bit done;

        sif.ld_valid = 1'b0;
        sif.ld_data  = 16'h0;
        model_reset();

        // Plain scan from reset, then a masked frame, then an unmask mid-slot.
        tbl.push_back('{3, 4'hF, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hF, 4'hE, 1'b1});
        tbl.push_back('{4, 4'hF, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hF, 4'hD, 1'b0});
        tbl.push_back('{4, 4'hF, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hF, 4'hB, 1'b0});
        tbl.push_back('{4, 4'hF, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hF, 4'h7, 1'b0});
        tbl.push_back('{4, 4'hF, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hA, 4'hF, 1'b1});
        tbl.push_back('{4, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hA, 4'hD, 1'b0});
        tbl.push_back('{4, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{4, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{8, 4'hA, 4'h7, 1'b0});
        tbl.push_back('{4, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{3, 4'hA, 4'hF, 1'b1});
        tbl.push_back('{5, 4'hF, 4'hE, 1'b0});
        tbl.push_back('{4, 4'hF, 4'hF, 1'b0});

        #12;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_nibble", 16'(nibble), 16'h0);
        chk("rst_fs", 16'(frame_start), 16'h0);
        chk("rst_ready", 16'(sif.ld_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                en_mask = tbl[i].en;
                step();
                chk("tbl_an", 16'(an), 16'(tbl[i].an_e));
                chk("tbl_fs", 16'(frame_start), (j == 0) ? 16'(tbl[i].fs_e) : 16'h0);
                chk("tbl_nib", 16'(nibble), 16'h0);
            end
        end

        // Load 4321 mid-frame (digit 1 slot).
        en_mask = 4'hF;
        sif.ld_valid = 1'b1;
        sif.ld_data  = 16'h4321;
        step();
        chk_model();
        sif.ld_valid = 1'b0;
        chk("ready_fall", 16'(sif.ld_ready), 16'h0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            chk_model();
            if (m_fs) done = 1;
        end
        chk("wait_fs_4321", 16'(done), 16'h1);
        chk("ready_rise_fs", 16'(sif.ld_ready), 16'h1);
        chk("d0_4321", 16'(nibble), 16'h1);
        run(48);

        // Back-pressure: AAAA accepted, 5555 held until ready returns.
        sif.ld_valid = 1'b1;
        sif.ld_data  = 16'hAAAA;
        step();
        chk_model();
        sif.ld_data = 16'h5555;
        done = 0;
        for (int i = 0; i < 150 && !done; i++) begin
            if (sif.ld_ready) begin
                chk("aaaa_applied", 16'(nibble), 16'hA);
                done = 1;
            end
            step();
            chk_model();
        end
        chk("wait_ready_5555", 16'(done), 16'h1);
        sif.ld_valid = 1'b0;
        run(100);

        // Load on the frame-boundary cycle with nothing pending.
        done = 0;
        for (int i = 0; i < 150 && !done; i++) begin
            step();
            chk_model();
            if (m_fs && m_ready) done = 1;
        end
        chk("wait_fs_idle", 16'(done), 16'h1);
        sif.ld_valid = 1'b1;
        sif.ld_data  = 16'hBEEF;
        step();
        chk_model();
        sif.ld_valid = 1'b0;
        chk("beef_old_frame", 16'(nibble), 16'h5);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            chk_model();
            if (m_fs) done = 1;
        end
        chk("wait_fs_beef", 16'(done), 16'h1);
        chk("beef_d0", 16'(nibble), 16'hF);
        run(48);

        // Random loads and mask changes; source holds data while not ready.
        for (int i = 0; i < 600; i++) begin
            if (!(sif.ld_valid && !sif.ld_ready)) begin
                sif.ld_valid = ($urandom_range(0, 5) == 0);
                sif.ld_data  = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) en_mask = 4'($urandom);
            step();
            chk_model();
        end
        sif.ld_valid = 1'b0;
        en_mask = 4'hF;

        // Asynchronous reset while digit 2 shows and a value is pending.
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            chk_model();
            if (m_ready && m_show && m_dig == 2 && ((t - INIT) % SLOT) == 0) done = 1;
        end
        chk("wait_d2", 16'(done), 16'h1);
        sif.ld_valid = 1'b1;
        sif.ld_data  = 16'h9876;
        step();
        chk_model();
        sif.ld_valid = 1'b0;
        chk("d2_pending", 16'(sif.ld_ready), 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an", 16'(an), 16'hF);
        chk("async_ready", 16'(sif.ld_ready), 16'h1);
        chk("async_fs", 16'(frame_start), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
